// File: rtl/alu_seq_ctrl_pkg.sv
// Shared constants and state encoding for the register-file/ALU sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: default operand/address widths shared with ALU and register file, FSM state type.
package alu_seq_pkg;

  // Default widths, shared with the ALU and register file.
  localparam int ALU_OP_W  = 4;
  localparam int RF_ADDR_W = 5;

  // State encoding is exposed on state_o for the LED display, so the values are fixed.
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command channel into the sequencer: one command per valid/ready handshake.
// Latency: n/a (wiring only). Backpressure: cmd_ready low means the command is dropped, not queued.
// Signals: cmd_valid/cmd_ready handshake, cmd_op, cmd_ra, cmd_rb, cmd_wa, cmd_we payload.
interface alu_seq_ctrl_if
  import alu_seq_pkg::*;
#(
  parameter int OP_W   = ALU_OP_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [ADDR_W-1:0] cmd_ra;
  logic [ADDR_W-1:0] cmd_rb;
  logic [ADDR_W-1:0] cmd_wa;
  logic              cmd_we;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_wa, cmd_we,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_wa, cmd_we,
    output cmd_ready
  );

endinterface

// File: rtl/alu_seq_ctrl_step_edge.sv
// Rising-edge detector for the (already synchronized) step button.
// Latency: step_rise is combinational from step, one cycle wide. Backpressure: none.
// Ports: clk, rst (sync, active-high), step in, step_rise out.
module step_edge (
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic step_rise
);

  logic step_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // A held button yields a single pulse: only the 0->1 transition counts.
  assign step_rise = step & ~step_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer driving the regfile/ALU datapath through READ -> EXEC -> WB -> DONE.
// Latency: free-run handshake at edge N gives rr_en@N+1, f_en@N+2, reg_write@N+3, done@N+4, ready@N+5.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are ignored.
// Ports: clk/rst (sync, active-high); cmd (slave command channel); step_mode/step debug advance;
//        r_addr_a/r_addr_b/w_addr/alu_op held datapath controls; rr_en/f_en/reg_write/done
//        one-cycle phase enables; busy and state_o status.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int OP_W   = ALU_OP_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  alu_seq_ctrl_if.slave      cmd,
  input  logic               step_mode,
  input  logic               step,
  output logic [ADDR_W-1:0]  r_addr_a,
  output logic [ADDR_W-1:0]  r_addr_b,
  output logic [ADDR_W-1:0]  w_addr,
  output logic [OP_W-1:0]    alu_op,
  output logic               rr_en,
  output logic               f_en,
  output logic               reg_write,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] state_o
);

  state_t state;
  state_t state_nxt;
  logic   step_rise;
  logic   adv;
  logic   hs;
  logic   we_q;

  step_edge u_step_edge (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .step_rise (step_rise)
  );

  // In free-run every busy cycle advances; in step mode only a fresh button press does.
  assign adv = ~step_mode | step_rise;

  assign cmd.cmd_ready = (state == S_IDLE);
  assign hs            = cmd.cmd_valid & cmd.cmd_ready;
  assign busy          = (state != S_IDLE);
  assign state_o       = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command fields stay visible to the datapath until the next accepted command.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_a <= '0;
      r_addr_b <= '0;
      w_addr   <= '0;
      alu_op   <= '0;
      we_q     <= 1'b0;
    end else if (hs) begin
      r_addr_a <= cmd.cmd_ra;
      r_addr_b <= cmd.cmd_rb;
      w_addr   <= cmd.cmd_wa;
      alu_op   <= cmd.cmd_op;
      we_q     <= cmd.cmd_we;
    end
  end

  // Each phase enable fires only in the cycle that leaves its state, so it is one cycle wide.
  always_comb begin
    state_nxt = state;
    rr_en     = 1'b0;
    f_en      = 1'b0;
    reg_write = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (hs) state_nxt = S_READ;
      end
      S_READ: begin
        if (adv) begin
          rr_en     = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (adv) begin
          f_en      = 1'b1;
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        // WB consumes an advance even when nothing is written back.
        if (adv) begin
          reg_write = we_q;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (adv) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A reset cycle aborts the transaction: the phase that would have completed is not issued.
    if (rst) begin
      rr_en     = 1'b0;
      f_en      = 1'b0;
      reg_write = 1'b0;
      done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  logic clk;
  logic rst;
  logic step_mode;
  logic step;
  logic [4:0] r_addr_a, r_addr_b, w_addr;
  logic [3:0] alu_op;
  logic rr_en, f_en, reg_write, busy, done;
  logic [2:0] state_o;

  int checks;
  int errors;

  alu_seq_ctrl_if #(.OP_W(4), .ADDR_W(5)) cmd_if ();

  alu_seq_ctrl #(.OP_W(4), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if),
    .step_mode (step_mode),
    .step      (step),
    .r_addr_a  (r_addr_a),
    .r_addr_b  (r_addr_b),
    .w_addr    (w_addr),
    .alu_op    (alu_op),
    .rr_en     (rr_en),
    .f_en      (f_en),
    .reg_write (reg_write),
    .busy      (busy),
    .done      (done),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] wa, input logic we);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_ra    = ra;
    cmd_if.cmd_rb    = rb;
    cmd_if.cmd_wa    = wa;
    cmd_if.cmd_we    = we;
  endtask

  // Free-run vectors: bit k-1 of each mask is the expected level in cycle k after handshake.
  typedef struct {
    logic [3:0] op;
    logic [4:0] ra, rb, wa;
    logic       we;
    logic [4:0] exp_rr, exp_f, exp_wr, exp_done, exp_rdy;
  } vec_t;

  vec_t vecs[4];

  // Reference model state: transaction-level view (phase index 0..3 of the current command).
  bit         m_busy;
  int         m_k;
  logic [3:0] m_op;
  logic [4:0] m_ra, m_rb, m_wa;
  logic       m_we;
  logic       m_prev_step;

  initial begin
    int n_rr, n_f, n_wr, n_done;
    logic adv_m;
    checks = 0;
    errors = 0;
    step_mode = 1'b0;
    step = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op = '0;
    cmd_if.cmd_ra = '0;
    cmd_if.cmd_rb = '0;
    cmd_if.cmd_wa = '0;
    cmd_if.cmd_we = 1'b0;

    vecs[0] = '{4'h1, 5'd3,  5'd5,  5'd7,  1'b1, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
    vecs[1] = '{4'hA, 5'd0,  5'd31, 5'd0,  1'b0, 5'b00001, 5'b00010, 5'b00000, 5'b01000, 5'b10000};
    vecs[2] = '{4'hF, 5'd31, 5'd0,  5'd31, 1'b1, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
    vecs[3] = '{4'h0, 5'd12, 5'd12, 5'd12, 1'b0, 5'b00001, 5'b00010, 5'b00000, 5'b01000, 5'b10000};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset state_o", state_o, 0);
    chk("reset busy", busy, 0);
    chk("reset cmd_ready", cmd_if.cmd_ready, 1);
    chk("reset r_addr_a", r_addr_a, 0);
    chk("reset r_addr_b", r_addr_b, 0);
    chk("reset w_addr", w_addr, 0);
    chk("reset alu_op", alu_op, 0);
    chk("reset enables", {rr_en, f_en, reg_write, done}, 0);
    next_cycle();

    // Table-driven free-run transactions
    for (int v = 0; v < 4; v++) begin
      set_cmd(vecs[v].op, vecs[v].ra, vecs[v].rb, vecs[v].wa, vecs[v].we);
      @(negedge clk);
      chk("vec ready at c0", cmd_if.cmd_ready, 1);
      next_cycle();
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_ra = 5'd9;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        chk("vec rr_en", rr_en, vecs[v].exp_rr[c-1]);
        chk("vec f_en", f_en, vecs[v].exp_f[c-1]);
        chk("vec reg_write", reg_write, vecs[v].exp_wr[c-1]);
        chk("vec done", done, vecs[v].exp_done[c-1]);
        chk("vec cmd_ready", cmd_if.cmd_ready, vecs[v].exp_rdy[c-1]);
        chk("vec r_addr_a", r_addr_a, vecs[v].ra);
        chk("vec r_addr_b", r_addr_b, vecs[v].rb);
        chk("vec w_addr", w_addr, vecs[v].wa);
        chk("vec alu_op", alu_op, vecs[v].op);
        next_cycle();
      end
    end

    // Step mode: a held button advances once; each further press advances one phase
    do_reset();
    step_mode = 1'b1;
    step = 1'b0;
    set_cmd(4'h6, 5'd1, 5'd2, 5'd4, 1'b1);
    next_cycle();
    cmd_if.cmd_valid = 1'b0;
    n_rr = 0; n_f = 0; n_wr = 0; n_done = 0;
    step = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_rr += int'(rr_en);
      n_f  += int'(f_en);
      next_cycle();
    end
    chk("step hold rr_en count", n_rr, 1);
    chk("step hold f_en count", n_f, 0);
    chk("step hold state EXEC", state_o, 2);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 3; c++) begin
        step = (c == 2);
        @(negedge clk);
        n_f    += int'(f_en);
        n_wr   += int'(reg_write);
        n_done += int'(done);
        next_cycle();
      end
    end
    step = 1'b0;
    @(negedge clk);
    chk("step f_en count", n_f, 1);
    chk("step reg_write count", n_wr, 1);
    chk("step done count", n_done, 1);
    chk("step back to IDLE", state_o, 0);
    chk("step cmd_ready", cmd_if.cmd_ready, 1);
    step_mode = 1'b0;

    // Busy rejection and back-to-back acceptance
    do_reset();
    set_cmd(4'h2, 5'd3, 5'd5, 5'd7, 1'b1);
    for (int c = 0; c <= 6; c++) begin
      cmd_if.cmd_ra = (c == 0) ? 5'd3 : 5'(10 + c);
      @(negedge clk);
      if (c == 0 || c == 5) chk("b2b cmd_ready high", cmd_if.cmd_ready, 1);
      if (c >= 1 && c <= 4) begin
        chk("b2b cmd_ready low", cmd_if.cmd_ready, 0);
        chk("b2b r_addr_a held", r_addr_a, 3);
      end
      if (c == 3) chk("b2b first reg_write", reg_write, 1);
      if (c == 6) begin
        chk("b2b second rr_en", rr_en, 1);
        chk("b2b second r_addr_a", r_addr_a, 15);
      end
      next_cycle();
    end
    cmd_if.cmd_valid = 1'b0;

    // Reset in EXEC aborts without f_en/reg_write
    do_reset();
    set_cmd(4'h3, 5'd8, 5'd9, 5'd10, 1'b1);
    next_cycle();
    cmd_if.cmd_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst state EXEC", state_o, 2);
    chk("midrst f_en suppressed", f_en, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst state IDLE", state_o, 0);
    chk("midrst busy", busy, 0);
    chk("midrst cmd_ready", cmd_if.cmd_ready, 1);
    chk("midrst addrs", {r_addr_a, r_addr_b, w_addr, alu_op}, 0);
    chk("midrst enables", {rr_en, f_en, reg_write, done}, 0);
    next_cycle();

    // Randomized run against the transaction-level model
    m_busy = 0; m_k = 0; m_op = '0; m_ra = '0; m_rb = '0; m_wa = '0; m_we = 0; m_prev_step = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = (i == 0) || ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 19) == 0) step_mode = ~step_mode;
      if ($urandom_range(0, 2) == 0) step = ~step;
      cmd_if.cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_if.cmd_op = 4'($urandom_range(0, 15));
      cmd_if.cmd_ra = 5'($urandom_range(0, 31));
      cmd_if.cmd_rb = 5'($urandom_range(0, 31));
      cmd_if.cmd_wa = 5'($urandom_range(0, 31));
      cmd_if.cmd_we = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      adv_m = !step_mode || (step && !m_prev_step);
      if (i > 0) begin
        chk("rnd cmd_ready", cmd_if.cmd_ready, !m_busy);
        chk("rnd busy", busy, m_busy);
        chk("rnd state_o", state_o, m_busy ? m_k + 1 : 0);
        chk("rnd rr_en", rr_en, !rst && m_busy && m_k == 0 && adv_m);
        chk("rnd f_en", f_en, !rst && m_busy && m_k == 1 && adv_m);
        chk("rnd reg_write", reg_write, !rst && m_busy && m_k == 2 && adv_m && m_we);
        chk("rnd done", done, !rst && m_busy && m_k == 3 && adv_m);
        chk("rnd addrs", {r_addr_a, r_addr_b, w_addr, alu_op}, {m_ra, m_rb, m_wa, m_op});
      end
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_k = 0; m_op = '0; m_ra = '0; m_rb = '0; m_wa = '0; m_we = 0;
        m_prev_step = 0;
      end else begin
        m_prev_step = step;
        if (m_busy) begin
          if (adv_m) begin
            if (m_k == 3) m_busy = 0;
            else m_k++;
          end
        end else if (cmd_if.cmd_valid) begin
          m_busy = 1; m_k = 0;
          m_op = cmd_if.cmd_op; m_ra = cmd_if.cmd_ra; m_rb = cmd_if.cmd_rb;
          m_wa = cmd_if.cmd_wa; m_we = cmd_if.cmd_we;
        end
      end
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle sequencer for the register-file/ALU datapath: register file, A/B operand registers, ALU, F/FR result registers.
- Accepts one command per transaction: op, two read addresses, write address, write flag.
- Drives the datapath through READ → EXEC → WB → DONE, producing one-cycle enables in place of hand-pulsed clocks (clk_RR, clk_F).
- Supports free-run and single-step (button-advanced) modes for board debugging.

Parameters:
OP_W, 4, width of ALU operation code
ADDR_W, 5, register address width (32 registers)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  OP_W  ALU operation
cmd_ra  input  ADDR_W  read address A
cmd_rb  input  ADDR_W  read address B
cmd_wa  input  ADDR_W  write-back address
cmd_we  input  1  write result back to register file
step_mode  input  1  1 = advance one phase per step press
step  input  1  step button level, already synchronized
r_addr_a  output  ADDR_W  to register file R_Addr_A
r_addr_b  output  ADDR_W  to register file R_Addr_B
w_addr  output  ADDR_W  to register file W_Addr
alu_op  output  OP_W  to ALU_OP
rr_en  output  1  load enable for A/B operand registers
f_en  output  1  load enable for F and FR registers
reg_write  output  1  register file write enable
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
state_o  output  3  current state encoding, for LED display

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state = IDLE.
  - r_addr_a, r_addr_b, w_addr, alu_op, the latched we flag, and the step edge register all = 0.
  - rr_en, f_en, reg_write, done, busy = 0; cmd_ready = 1 after reset releases.
- States: IDLE=0, READ=1, EXEC=2, WB=3, DONE=4. Encodings 5–7 are illegal and return to IDLE on the next edge.
- cmd_ready = (state==IDLE). Handshake occurs when cmd_valid && cmd_ready.
- On handshake:
  - Latch op/ra/rb/wa/we into the output registers.
  - Go to READ.
  - cmd_valid while not ready is ignored; commands are not queued.
- Address and op outputs hold stable from handshake until the next handshake, including while in IDLE.
- adv = ~step_mode | step_rise, where step_rise is a one-cycle pulse on a 0→1 transition of step.
- In READ, EXEC, WB and DONE, the state advances only when adv=1. The phase output is combinational, asserted only in the advancing cycle, so each is exactly one cycle wide per transaction:
  - READ: rr_en = 1 when adv → EXEC
  - EXEC: f_en = 1 when adv → WB
  - WB: reg_write = latched we when adv → DONE. If we=0, WB still takes one advance but writes nothing.
  - DONE: done = 1 when adv → IDLE
- Free-run latency:
  - Handshake at edge N.
  - rr_en high during cycle N+1, f_en N+2, reg_write N+3, done N+4.
  - cmd_ready high again from cycle N+5; back-to-back throughput is 1 command per 5 cycles.
- Step mode: each rising edge of step advances exactly one phase. A held button does not repeat.
- step_mode may change at any time; it takes effect in the same cycle it is sampled.
- A step press while in IDLE is ignored and is not remembered.
- Reset mid-transaction: takes effect at that edge, with no pending enable issued. rst has priority over a simultaneous handshake.
- reg_write and f_en are never high in the same cycle. rr_en never overlaps either of them.

Decomposition:
- Shared package alu_seq_pkg:
  - State localparams: S_IDLE .. S_DONE and state width 3.
  - Default OP_W and ADDR_W constants, shared with the ALU and register file.
- One sub-module, step_edge:
  - Single register, synchronous active-high reset.
  - Outputs step_rise = step & ~step_q.

Test Plan:
- Reset then free-run: cmd op=4'h1, ra=3, rb=5, wa=7, we=1 at cycle 0 → rr_en@1, f_en@2, reg_write@3 with w_addr=7, done@4, cmd_ready@5. Addresses stay 3/5/7 throughout.
- cmd_we=0: sequence identical, reg_write stays 0 for all cycles, done still @4.
- Step mode: step_mode=1, accept cmd, hold step=1 for 10 cycles → exactly one phase advance (rr_en once). Three further presses → f_en, reg_write, done once each, then IDLE.
- Busy rejection: cmd_valid held high with changing ra during busy → latched r_addr_a stays at the first value. The second command is accepted only at cycle 5.
- Reset mid-op: rst=1 in EXEC cycle → next cycle state=IDLE, no f_en/reg_write pulse, all addresses 0, cmd_ready=1.
- Back-to-back: two commands with cmd_valid held → handshakes at cycles 0 and 5. The reg_write of the first (cycle 3) precedes rr_en of the second (cycle 6).
